// File: rtl/trans_pkg.sv
// Shared types and constants for the transaction-layer flow controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package trans_pkg;
    localparam int TH_WIDTH  = 3;
    localparam int CNT_WIDTH = 5;
    localparam int NUM_OUT   = 4;
    localparam int IDX_WIDTH = 3;

    localparam logic [TH_WIDTH-1:0] DEF_TH_AF = 3'd6;
    localparam logic [TH_WIDTH-1:0] DEF_TH_AE = 3'd1;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    function automatic logic [NUM_OUT-1:0] dest_onehot(input logic [1:0] dest);
        return NUM_OUT'(1) << dest;
    endfunction
endpackage

// File: rtl/trans_flow_ctrl_if.sv
// Handshake/status bundle between the flow controller and its FIFOs/consumers.
// Latency: n/a (wires only).
// Backpressure: carried by fifo_almost_full toward the controller.
interface trans_flow_ctrl_if;
    import trans_pkg::*;

    logic                  init;
    logic [TH_WIDTH-1:0]   th_almost_full_in;
    logic [TH_WIDTH-1:0]   th_almost_empty_in;
    logic                  main_empty;
    logic [1:0]            head_dest;
    logic [NUM_OUT-1:0]    fifo_almost_full;
    logic [NUM_OUT-1:0]    fifo_empty;
    logic [NUM_OUT:0]      fifo_error;
    logic [NUM_OUT-1:0]    pop_out;
    logic                  req;
    logic [IDX_WIDTH-1:0]  idx;

    logic [TH_WIDTH-1:0]   th_almost_full;
    logic [TH_WIDTH-1:0]   th_almost_empty;
    logic                  main_pop;
    logic [NUM_OUT-1:0]    demux_push;
    logic                  idle_out;
    logic                  active_out;
    logic                  error_out;
    logic [CNT_WIDTH-1:0]  data_out_cont;
    logic                  valid_cont;

    modport master (
        input  init, th_almost_full_in, th_almost_empty_in, main_empty, head_dest,
               fifo_almost_full, fifo_empty, fifo_error, pop_out, req, idx,
        output th_almost_full, th_almost_empty, main_pop, demux_push,
               idle_out, active_out, error_out, data_out_cont, valid_cont
    );

    modport slave (
        output init, th_almost_full_in, th_almost_empty_in, main_empty, head_dest,
               fifo_almost_full, fifo_empty, fifo_error, pop_out, req, idx,
        input  th_almost_full, th_almost_empty, main_pop, demux_push,
               idle_out, active_out, error_out, data_out_cont, valid_cont
    );
endinterface

// File: rtl/trans_cnt_bank.sv
// Per-output pop counters with registered readout; TRANS_CTRL_CNT_SAT_EN selects saturate vs wrap.
// Latency: readout valid one cycle after rd_en.
// Backpressure: none, counts every enabled pop.
module trans_cnt_bank
    import trans_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 cnt_en,
    input  logic [NUM_OUT-1:0]   pop,
    input  logic                 rd_en,
    input  logic [IDX_WIDTH-1:0] rd_idx,
    output logic [CNT_WIDTH-1:0] rd_dat,
    output logic                 rd_vld
);
    logic [CNT_WIDTH-1:0] cnt [NUM_OUT];

`ifdef TRANS_CTRL_CNT_SAT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
            rd_vld <= 1'b0;
            rd_dat <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (cnt_en && pop[i]) begin
`ifdef TRANS_CTRL_CNT_SAT_EN
                    if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
`else
                    cnt[i] <= cnt[i] + 1'b1;
`endif
                end
            end
            // Samples the pre-increment value when a pop lands on the same edge.
            rd_vld <= rd_en;
            rd_dat <= (rd_en && !rd_idx[2]) ? cnt[rd_idx[1:0]] : '0;
        end
    end
endmodule

// File: rtl/trans_flow_ctrl.sv
// Transaction-layer control FSM: thresholds, main-FIFO pop scheduling, 1-of-4 demux steering (counters: see TRANS_CTRL_CNT_SAT_EN).
// Latency: demux_push follows main_pop by one cycle (main FIFO read latency).
// Backpressure: head word stalls while its destination FIFO is almost-full; no reordering.
module trans_flow_ctrl
    import trans_pkg::*;
(
    input  logic               clk,
    input  logic               reset_L,
    trans_flow_ctrl_if.master  bus
);
    state_t              state;
    logic [TH_WIDTH-1:0] th_af_q;
    logic [TH_WIDTH-1:0] th_ae_q;
    logic                pend_q;
    logic [1:0]          dest_q;
    logic                main_pop;
    logic                cnt_en;
    logic                rd_en;

    assign main_pop = (state == ST_ACTIVE) && !bus.main_empty
                      && !bus.fifo_almost_full[bus.head_dest];

    // A word popped on the edge into ERROR must not be pushed.
    assign bus.demux_push      = (pend_q && state == ST_ACTIVE) ? dest_onehot(dest_q) : '0;
    assign bus.main_pop        = main_pop;
    assign bus.th_almost_full  = th_af_q;
    assign bus.th_almost_empty = th_ae_q;
    assign bus.idle_out        = (state == ST_IDLE);
    assign bus.active_out      = (state == ST_ACTIVE);
    assign bus.error_out       = (state == ST_ERROR);

    assign cnt_en = (state != ST_RESET) && (state != ST_ERROR);
    assign rd_en  = bus.req && (state == ST_IDLE);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state   <= ST_RESET;
            th_af_q <= DEF_TH_AF;
            th_ae_q <= DEF_TH_AE;
            pend_q  <= 1'b0;
            dest_q  <= '0;
        end else begin
            pend_q <= main_pop;
            if (main_pop) dest_q <= bus.head_dest;
            if (state == ST_INIT) begin
                th_af_q <= bus.th_almost_full_in;
                th_ae_q <= bus.th_almost_empty_in;
            end

            if (state == ST_RESET) begin
                state <= ST_INIT;
            end else if (|bus.fifo_error) begin
                state <= ST_ERROR;
            end else begin
                case (state)
                    ST_INIT:   if (!bus.init) state <= ST_IDLE;
                    ST_IDLE: begin
                        if (bus.init)             state <= ST_INIT;
                        else if (!bus.main_empty) state <= ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (bus.main_empty && (&bus.fifo_empty) && !pend_q)
                            state <= ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    trans_cnt_bank u_cnt_bank (
        .clk     (clk),
        .reset_L (reset_L),
        .cnt_en  (cnt_en),
        .pop     (bus.pop_out),
        .rd_en   (rd_en),
        .rd_idx  (bus.idx),
        .rd_dat  (bus.data_out_cont),
        .rd_vld  (bus.valid_cont)
    );
endmodule

// File: tb/tb_trans_flow_ctrl.sv
// Randomized bench for trans_flow_ctrl against a transaction-level reference model.
module tb_trans_flow_ctrl;
    import trans_pkg::*;

    localparam int M_RST = 0, M_INIT = 1, M_IDLE = 2, M_ACT = 3, M_ERR = 4;
`ifdef TRANS_CTRL_CNT_SAT_EN
    localparam int EXP_OVF = 31;
`else
    localparam int EXP_OVF = 1;
`endif

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    trans_flow_ctrl_if bus();

    trans_flow_ctrl dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    // reference model
    int ms;
    int th_af, th_ae;
    int cnt [4];
    int infl;
    int exp_vld, exp_dat;

    // environment: main FIFO contents (destinations) and output FIFO occupancy
    int mq [$];
    int occ [4];

    // stimulus knobs
    int init_i = 0, thf_i = 0, the_i = 0, req_i = 0, idx_i = 0;
    int af_i = 0, pop_i = 0, err_i = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input int exp_pop, input int exp_push);
        chk("main_pop",   int'(bus.main_pop),        exp_pop);
        chk("demux_push", int'(bus.demux_push),      exp_push);
        chk("idle_out",   int'(bus.idle_out),        (ms == M_IDLE) ? 1 : 0);
        chk("active_out", int'(bus.active_out),      (ms == M_ACT)  ? 1 : 0);
        chk("error_out",  int'(bus.error_out),       (ms == M_ERR)  ? 1 : 0);
        chk("th_af",      int'(bus.th_almost_full),  th_af);
        chk("th_ae",      int'(bus.th_almost_empty), th_ae);
        chk("valid_cont", int'(bus.valid_cont),      exp_vld);
        chk("data_cont",  int'(bus.data_out_cont),   exp_dat);
    endtask

    // Called at a negedge: drive, check, advance the model, move to the next negedge.
    task automatic step();
        int hd, exp_pop, exp_push, nms, ie;
        int old_occ [4];
        hd = (mq.size() != 0) ? mq[0] : 0;
        bus.init               = init_i[0];
        bus.th_almost_full_in  = thf_i[2:0];
        bus.th_almost_empty_in = the_i[2:0];
        bus.main_empty         = (mq.size() == 0);
        bus.head_dest          = hd[1:0];
        bus.fifo_almost_full   = af_i[3:0];
        for (int i = 0; i < 4; i++) bus.fifo_empty[i] = (occ[i] == 0);
        bus.fifo_error         = err_i[4:0];
        bus.pop_out            = pop_i[3:0];
        bus.req                = req_i[0];
        bus.idx                = idx_i[2:0];
        #1;
        exp_pop  = (ms == M_ACT && mq.size() != 0 && af_i[hd] == 0) ? 1 : 0;
        exp_push = (ms == M_ACT && infl >= 0) ? (1 << infl) : 0;
        check_outputs(exp_pop, exp_push);

        nms = ms;
        if (ms == M_RST) nms = M_INIT;
        else if (err_i != 0) nms = M_ERR;
        else if (ms == M_INIT) begin
            if (init_i == 0) nms = M_IDLE;
        end else if (ms == M_IDLE) begin
            if (init_i != 0) nms = M_INIT;
            else if (mq.size() != 0) nms = M_ACT;
        end else if (ms == M_ACT) begin
            ie = 1;
            for (int i = 0; i < 4; i++) if (occ[i] != 0) ie = 0;
            if (mq.size() == 0 && ie == 1 && infl < 0) nms = M_IDLE;
        end
        if (ms == M_INIT) begin
            th_af = thf_i & 7;
            th_ae = the_i & 7;
        end

        exp_vld = (req_i != 0 && ms == M_IDLE) ? 1 : 0;
        exp_dat = (exp_vld == 1 && idx_i < 4) ? cnt[idx_i] : 0;
        if (ms != M_RST && ms != M_ERR) begin
            for (int i = 0; i < 4; i++) begin
                if (pop_i[i]) begin
`ifdef TRANS_CTRL_CNT_SAT_EN
                    cnt[i] = (cnt[i] >= 31) ? 31 : cnt[i] + 1;
`else
                    cnt[i] = (cnt[i] + 1) % 32;
`endif
                end
            end
        end

        for (int i = 0; i < 4; i++) old_occ[i] = occ[i];
        if (exp_push != 0) occ[infl]++;
        for (int i = 0; i < 4; i++) if (pop_i[i] && old_occ[i] > 0) occ[i]--;
        infl = -1;
        if (exp_pop == 1) infl = mq.pop_front();
        ms = nms;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        reset_L = 1'b0;
        #1;
        ms = M_RST; th_af = 6; th_ae = 1; infl = -1; exp_vld = 0; exp_dat = 0;
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; occ[i] = 0; end
        mq.delete();
        check_outputs(0, 0);
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs(0, 0);
        end
        reset_L = 1'b1;
    endtask

    task automatic init_seq();
        init_i = 1; thf_i = 5; the_i = 2; req_i = 0; pop_i = 0; af_i = 0; err_i = 0;
        repeat (3) step();
        init_i = 0;
        step();
        thf_i = 0; the_i = 0;
        step();
        chk("th_af_kept", int'(bus.th_almost_full), 5);
        chk("th_ae_kept", int'(bus.th_almost_empty), 2);
        chk("idle_after_init", int'(bus.idle_out), 1);
    endtask

    task automatic drain();
        pop_i = 15; af_i = 0; req_i = 0; init_i = 0; err_i = 0;
        for (int k = 0; k < 80 && ms != M_IDLE; k++) step();
        step();
        chk("idle_reached", int'(bus.idle_out), 1);
        pop_i = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset(2);
        init_seq();

        // counter readout
        pop_i = 2;
        repeat (3) step();
        pop_i = 0; req_i = 1; idx_i = 1;
        step();
        chk("cnt1_vld", int'(bus.valid_cont), 1);
        chk("cnt1_val", int'(bus.data_out_cont), 3);
        idx_i = 6;
        step();
        chk("idx6_vld", int'(bus.valid_cont), 1);
        chk("idx6_val", int'(bus.data_out_cont), 0);
        req_i = 0;

        // counter overflow on output 0
        pop_i = 1;
        repeat (33) step();
        pop_i = 0; req_i = 1; idx_i = 0;
        step();
        chk("ovf_val", int'(bus.data_out_cont), EXP_OVF);
        req_i = 0;

        // dispatch of four words, req ignored while active
        for (int d = 0; d < 4; d++) mq.push_back(d);
        req_i = 1; idx_i = 1;
        repeat (6) step();
        chk("req_active_vld", int'(bus.valid_cont), 0);
        req_i = 0;
        drain();

        // stall on destination 2
        mq.push_back(2); mq.push_back(1);
        af_i = 4;
        repeat (6) step();
        chk("stall_hold", int'(bus.main_pop), 0);
        af_i = 0;
        step();
        drain();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            init_i = ($urandom_range(0, 15) == 0) ? 1 : 0;
            thf_i  = $urandom_range(0, 7);
            the_i  = $urandom_range(0, 7);
            req_i  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            idx_i  = $urandom_range(0, 7);
            af_i   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 0;
            pop_i  = $urandom_range(0, 15);
            if (mq.size() < 6 && $urandom_range(0, 2) == 0) mq.push_back($urandom_range(0, 3));
            step();
        end
        drain();

        // sticky error from ACTIVE
        for (int d = 0; d < 5; d++) mq.push_back(d % 4);
        step();
        step();
        err_i = 16;
        step();
        err_i = 0; pop_i = 15;
        repeat (5) step();
        chk("err_sticky", int'(bus.error_out), 1);
        chk("err_no_pop", int'(bus.main_pop), 0);
        pop_i = 0;

        // reset clears counters and leaves ERROR
        do_reset(2);
        init_seq();
        req_i = 1; idx_i = 0;
        step();
        chk("post_reset_cnt", int'(bus.data_out_cont), 0);
        req_i = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
